// File: rtl/umi_mem_arb_pkg.sv
// Shared types and helpers for the UMI memory arbiter: FSM states, port-ID width and
// the port-ID extraction used to route responses. No logic, no latency.
package umi_mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Widest address and port-ID field the extraction helper handles (NREQ <= 16).
  localparam int MAX_AW  = 128;
  localparam int MAX_IDW = 4;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_IDW-1:0] extract_id(input logic [MAX_AW-1:0] addr,
                                                    input int lsb, input int w);
    logic [MAX_AW-1:0] mask;
    mask = (MAX_AW'(1) << w) - MAX_AW'(1);
    return MAX_IDW'((addr >> lsb) & mask);
  endfunction

endpackage

// File: rtl/umi_rr_arbiter.sv
// Round-robin rotate-priority encoder: first asserted req after last_grant, circularly.
// Purely combinational, zero latency; no backpressure of its own.
module umi_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    // Offset 1 first so the last winner is checked last.
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_grant) + i) % NREQ);
      if (!grant_any && req[idx]) begin
        grant_any     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umi_mem_arbiter.sv
// Shares one UMI device between NREQ requesters: round-robin request mux with a grant lock
// while stalled, ID-routed response demux. Zero added latency; ready passes straight through.
module umi_mem_arbiter
  import umi_mem_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int IDLSB = 40
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [NREQ-1:0]   host_req_valid,
  input  logic [NREQ*CW-1:0] host_req_cmd,
  input  logic [NREQ*AW-1:0] host_req_dstaddr,
  input  logic [NREQ*AW-1:0] host_req_srcaddr,
  input  logic [NREQ*DW-1:0] host_req_data,
  output logic [NREQ-1:0]   host_req_ready,
  output logic              udev_req_valid,
  output logic [CW-1:0]     udev_req_cmd,
  output logic [AW-1:0]     udev_req_dstaddr,
  output logic [AW-1:0]     udev_req_srcaddr,
  output logic [DW-1:0]     udev_req_data,
  input  logic              udev_req_ready,
  input  logic              udev_resp_valid,
  input  logic [CW-1:0]     udev_resp_cmd,
  input  logic [AW-1:0]     udev_resp_dstaddr,
  input  logic [AW-1:0]     udev_resp_srcaddr,
  input  logic [DW-1:0]     udev_resp_data,
  output logic              udev_resp_ready,
  output logic [NREQ-1:0]   host_resp_valid,
  output logic [CW-1:0]     host_resp_cmd,
  output logic [AW-1:0]     host_resp_dstaddr,
  output logic [AW-1:0]     host_resp_srcaddr,
  output logic [DW-1:0]     host_resp_data,
  input  logic [NREQ-1:0]   host_resp_ready,
  output logic              grant_locked
);

  localparam int IDW = id_width(NREQ);

  arb_state_t      state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  locked_port;
  logic [IDW-1:0]  rr_idx;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  resp_id;
  logic [NREQ-1:0] rr_oh;
  logic            rr_any;
  logic            req_vld;
  logic            dev_rdy;
  logic            resp_id_ok;

  umi_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req        (host_req_valid),
    .last_grant (last_grant),
    .grant_oh   (rr_oh),
    .grant_idx  (rr_idx),
    .grant_any  (rr_any)
  );

  // ---------------- request path ----------------
  assign grant   = (state == LOCKED) ? locked_port : rr_idx;
  assign req_vld = nreset & host_req_valid[grant];
  assign dev_rdy = nreset & udev_req_ready;

  assign udev_req_valid   = req_vld;
  assign udev_req_cmd     = host_req_cmd[grant*CW +: CW];
  assign udev_req_dstaddr = host_req_dstaddr[grant*AW +: AW];
  assign udev_req_srcaddr = host_req_srcaddr[grant*AW +: AW];
  assign udev_req_data    = host_req_data[grant*DW +: DW];

  always_comb begin
    host_req_ready = '0;
    if (state == LOCKED) begin
      host_req_ready[locked_port] = dev_rdy;
    end else begin
      host_req_ready = rr_oh & {NREQ{dev_rdy}};
    end
  end

  // A stalled grant is frozen so the requester's valid/payload stay on the bus untouched.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      locked_port  <= '0;
      grant_locked <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_any) begin
            if (udev_req_ready) begin
              last_grant <= rr_idx;
            end else begin
              state        <= LOCKED;
              locked_port  <= rr_idx;
              grant_locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!host_req_valid[locked_port]) begin
            // Requester withdrew mid-stall: release without crediting a transfer.
            state        <= IDLE;
            grant_locked <= 1'b0;
          end else if (udev_req_ready) begin
            state        <= IDLE;
            last_grant   <= locked_port;
            grant_locked <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          grant_locked <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- response path ----------------
  assign resp_id    = IDW'(extract_id(MAX_AW'(udev_resp_dstaddr), IDLSB, IDW));
  assign resp_id_ok = (int'(resp_id) < NREQ);

  always_comb begin
    host_resp_valid = '0;
    if (nreset && udev_resp_valid && resp_id_ok) begin
      host_resp_valid[resp_id] = 1'b1;
    end
  end

  // Responses to nonexistent ports are sunk so the device never wedges.
  assign udev_resp_ready = nreset & (resp_id_ok ? host_resp_ready[resp_id] : 1'b1);

  assign host_resp_cmd     = udev_resp_cmd;
  assign host_resp_dstaddr = udev_resp_dstaddr;
  assign host_resp_srcaddr = udev_resp_srcaddr;
  assign host_resp_data    = udev_resp_data;

endmodule

// File: tb/tb_umi_mem_arbiter.sv
// Bench for umi_mem_arbiter: request-path vector table with a transfer scoreboard,
// response routing table across a 4-port and a 3-port instance, and reset corner cases.
module tb_umi_mem_arbiter;

  localparam int NREQ  = 4;
  localparam int N3    = 3;
  localparam int CW    = 32;
  localparam int AW    = 64;
  localparam int DW    = 256;
  localparam int IDLSB = 40;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [NREQ-1:0]    host_req_valid;
  logic [NREQ*CW-1:0] host_req_cmd;
  logic [NREQ*AW-1:0] host_req_dstaddr;
  logic [NREQ*AW-1:0] host_req_srcaddr;
  logic [NREQ*DW-1:0] host_req_data;
  logic [NREQ-1:0]    host_req_ready;
  logic               udev_req_valid;
  logic [CW-1:0]      udev_req_cmd;
  logic [AW-1:0]      udev_req_dstaddr;
  logic [AW-1:0]      udev_req_srcaddr;
  logic [DW-1:0]      udev_req_data;
  logic               udev_req_ready;
  logic               udev_resp_valid;
  logic [CW-1:0]      udev_resp_cmd;
  logic [AW-1:0]      udev_resp_dstaddr;
  logic [AW-1:0]      udev_resp_srcaddr;
  logic [DW-1:0]      udev_resp_data;
  logic               udev_resp_ready;
  logic [NREQ-1:0]    host_resp_valid;
  logic [CW-1:0]      host_resp_cmd;
  logic [AW-1:0]      host_resp_dstaddr;
  logic [AW-1:0]      host_resp_srcaddr;
  logic [DW-1:0]      host_resp_data;
  logic [NREQ-1:0]    host_resp_ready;
  logic               grant_locked;

  // 3-port instance, shares the response inputs
  logic [N3-1:0]    h3_req_valid;
  logic [N3*CW-1:0] h3_req_cmd;
  logic [N3*AW-1:0] h3_req_dstaddr;
  logic [N3*AW-1:0] h3_req_srcaddr;
  logic [N3*DW-1:0] h3_req_data;
  logic [N3-1:0]    h3_req_ready;
  logic             u3_req_valid;
  logic [CW-1:0]    u3_req_cmd;
  logic [AW-1:0]    u3_req_dstaddr;
  logic [AW-1:0]    u3_req_srcaddr;
  logic [DW-1:0]    u3_req_data;
  logic             u3_req_ready;
  logic             u3_resp_ready;
  logic [N3-1:0]    h3_resp_valid;
  logic [CW-1:0]    h3_resp_cmd;
  logic [AW-1:0]    h3_resp_dstaddr;
  logic [AW-1:0]    h3_resp_srcaddr;
  logic [DW-1:0]    h3_resp_data;
  logic [N3-1:0]    h3_resp_ready;
  logic             u3_grant_locked;

  umi_mem_arbiter #(.NREQ(NREQ), .CW(CW), .AW(AW), .DW(DW), .IDLSB(IDLSB)) u_dut (
    .clk               (clk),
    .nreset            (nreset),
    .host_req_valid    (host_req_valid),
    .host_req_cmd      (host_req_cmd),
    .host_req_dstaddr  (host_req_dstaddr),
    .host_req_srcaddr  (host_req_srcaddr),
    .host_req_data     (host_req_data),
    .host_req_ready    (host_req_ready),
    .udev_req_valid    (udev_req_valid),
    .udev_req_cmd      (udev_req_cmd),
    .udev_req_dstaddr  (udev_req_dstaddr),
    .udev_req_srcaddr  (udev_req_srcaddr),
    .udev_req_data     (udev_req_data),
    .udev_req_ready    (udev_req_ready),
    .udev_resp_valid   (udev_resp_valid),
    .udev_resp_cmd     (udev_resp_cmd),
    .udev_resp_dstaddr (udev_resp_dstaddr),
    .udev_resp_srcaddr (udev_resp_srcaddr),
    .udev_resp_data    (udev_resp_data),
    .udev_resp_ready   (udev_resp_ready),
    .host_resp_valid   (host_resp_valid),
    .host_resp_cmd     (host_resp_cmd),
    .host_resp_dstaddr (host_resp_dstaddr),
    .host_resp_srcaddr (host_resp_srcaddr),
    .host_resp_data    (host_resp_data),
    .host_resp_ready   (host_resp_ready),
    .grant_locked      (grant_locked)
  );

  umi_mem_arbiter #(.NREQ(N3), .CW(CW), .AW(AW), .DW(DW), .IDLSB(IDLSB)) u_dut3 (
    .clk               (clk),
    .nreset            (nreset),
    .host_req_valid    (h3_req_valid),
    .host_req_cmd      (h3_req_cmd),
    .host_req_dstaddr  (h3_req_dstaddr),
    .host_req_srcaddr  (h3_req_srcaddr),
    .host_req_data     (h3_req_data),
    .host_req_ready    (h3_req_ready),
    .udev_req_valid    (u3_req_valid),
    .udev_req_cmd      (u3_req_cmd),
    .udev_req_dstaddr  (u3_req_dstaddr),
    .udev_req_srcaddr  (u3_req_srcaddr),
    .udev_req_data     (u3_req_data),
    .udev_req_ready    (u3_req_ready),
    .udev_resp_valid   (udev_resp_valid),
    .udev_resp_cmd     (udev_resp_cmd),
    .udev_resp_dstaddr (udev_resp_dstaddr),
    .udev_resp_srcaddr (udev_resp_srcaddr),
    .udev_resp_data    (udev_resp_data),
    .udev_resp_ready   (u3_resp_ready),
    .host_resp_valid   (h3_resp_valid),
    .host_resp_cmd     (h3_resp_cmd),
    .host_resp_dstaddr (h3_resp_dstaddr),
    .host_resp_srcaddr (h3_resp_srcaddr),
    .host_resp_data    (h3_resp_data),
    .host_resp_ready   (h3_resp_ready),
    .grant_locked      (u3_grant_locked)
  );

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic       exp_vld;
    logic [3:0] exp_hrdy;
    int         exp_port;
    logic       exp_lk;
  } vec_t;

  typedef struct {
    logic       v;
    int         id;
    logic [3:0] hr4;
    logic [2:0] hr3;
    logic [3:0] ehv4;
    logic       eur4;
    logic [2:0] ehv3;
    logic       eur3;
  } rvec_t;

  vec_t  tbl  [0:15];
  rvec_t rtbl [0:8];

  int n_cmp  = 0;
  int n_fail = 0;
  int sb_q [$];
  int sb_p;

  function automatic logic [DW-1:0] pdata(input int p);
    logic [7:0] b;
    b = 8'hA3 + 8'(p);
    return {(DW/8){b}};
  endfunction

  function automatic logic [CW-1:0] pcmd(input int p);
    return 32'hC0DE_0000 + 32'(p);
  endfunction

  function automatic logic [AW-1:0] pdst(input int p);
    return 64'h0000_00D5_0000_0000 + 64'(p);
  endfunction

  function automatic logic [AW-1:0] psrc(input int p);
    return (64'(p) << IDLSB) | 64'h5000;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input int k);
    @(posedge clk);
    #1;
    host_req_valid = v.vld;
    udev_req_ready = v.rdy;
    if (v.exp_vld && v.rdy) sb_q.push_back(v.exp_port);
    @(negedge clk);
    chk($sformatf("row%0d_udev_req_valid", k), udev_req_valid, v.exp_vld);
    chk($sformatf("row%0d_host_req_ready", k), host_req_ready, v.exp_hrdy);
    chk($sformatf("row%0d_grant_locked", k), grant_locked, v.exp_lk);
    if (v.exp_vld) begin
      chk($sformatf("row%0d_data", k), udev_req_data, pdata(v.exp_port));
      chk($sformatf("row%0d_cmd_dst", k), {udev_req_cmd, udev_req_dstaddr},
          {pcmd(v.exp_port), pdst(v.exp_port)});
    end
  endtask

  task automatic apply_resp(input rvec_t r, input int k);
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    d   = {(DW/32){32'h5EED_0000 + 32'(k)}};
    c   = 32'h0E50_0000 + 32'(k);
    src = 64'h1234_0000 + 64'(k);
    // bits 42/43 set on purpose: must not leak into the port ID
    dst = 64'h0000_0C00_0000_1234 | (64'(r.id) << IDLSB);
    @(posedge clk);
    #1;
    udev_resp_valid   = r.v;
    udev_resp_data    = d;
    udev_resp_cmd     = c;
    udev_resp_srcaddr = src;
    udev_resp_dstaddr = dst;
    host_resp_ready   = r.hr4;
    h3_resp_ready     = r.hr3;
    @(negedge clk);
    chk($sformatf("resp%0d_host_resp_valid", k), host_resp_valid, r.ehv4);
    chk($sformatf("resp%0d_udev_resp_ready", k), udev_resp_ready, r.eur4);
    chk($sformatf("resp%0d_n3_host_resp_valid", k), h3_resp_valid, r.ehv3);
    chk($sformatf("resp%0d_n3_udev_resp_ready", k), u3_resp_ready, r.eur3);
    chk($sformatf("resp%0d_bcast", k), {host_resp_cmd, host_resp_dstaddr, host_resp_srcaddr, host_resp_data},
        {c, dst, src, d});
    chk($sformatf("resp%0d_n3_bcast", k), {h3_resp_cmd, h3_resp_dstaddr, h3_resp_srcaddr, h3_resp_data},
        {c, dst, src, d});
  endtask

  // Scoreboard: each accepted request must match the port the table expected to win.
  always @(negedge clk) begin
    if (nreset && udev_req_valid && udev_req_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got transfer with src %0h, expected none", udev_req_srcaddr);
      end else begin
        sb_p = sb_q.pop_front();
        chk("sb_data", udev_req_data, pdata(sb_p));
        chk("sb_src", udev_req_srcaddr, psrc(sb_p));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    // rotation from reset, idle, fairness, lock with a higher-priority intruder, release
    tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 0, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 2, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 3, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1'b0};
    tbl[6]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 0, 1'b0};
    tbl[7]  = '{4'b1001, 1'b1, 1'b1, 4'b1000, 3, 1'b0};
    tbl[8]  = '{4'b1011, 1'b1, 1'b1, 4'b0001, 0, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
    tbl[10] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2, 1'b0};
    tbl[11] = '{4'b0110, 1'b0, 1'b1, 4'b0000, 2, 1'b1};
    tbl[12] = '{4'b0110, 1'b0, 1'b1, 4'b0000, 2, 1'b1};
    tbl[13] = '{4'b0110, 1'b1, 1'b1, 4'b0100, 2, 1'b1};
    tbl[14] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 1, 1'b0};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0};

    rtbl[0] = '{1'b1, 2, 4'b0000, 3'b000, 4'b0100, 1'b0, 3'b100, 1'b0};
    rtbl[1] = '{1'b1, 2, 4'b0100, 3'b100, 4'b0100, 1'b1, 3'b100, 1'b1};
    rtbl[2] = '{1'b1, 2, 4'b1011, 3'b011, 4'b0100, 1'b0, 3'b100, 1'b0};
    rtbl[3] = '{1'b1, 0, 4'b0001, 3'b001, 4'b0001, 1'b1, 3'b001, 1'b1};
    rtbl[4] = '{1'b1, 3, 4'b1000, 3'b000, 4'b1000, 1'b1, 3'b000, 1'b1};
    rtbl[5] = '{1'b1, 3, 4'b0000, 3'b111, 4'b1000, 1'b0, 3'b000, 1'b1};
    rtbl[6] = '{1'b1, 1, 4'b0000, 3'b000, 4'b0010, 1'b0, 3'b010, 1'b0};
    rtbl[7] = '{1'b0, 1, 4'b0010, 3'b010, 4'b0000, 1'b1, 3'b000, 1'b1};
    rtbl[8] = '{1'b0, 3, 4'b0000, 3'b000, 4'b0000, 1'b0, 3'b000, 1'b1};

    for (int p = 0; p < NREQ; p++) begin
      host_req_cmd[p*CW +: CW]     = pcmd(p);
      host_req_dstaddr[p*AW +: AW] = pdst(p);
      host_req_srcaddr[p*AW +: AW] = psrc(p);
      host_req_data[p*DW +: DW]    = pdata(p);
    end
    h3_req_valid   = '0;
    h3_req_cmd     = '0;
    h3_req_dstaddr = '0;
    h3_req_srcaddr = '0;
    h3_req_data    = '0;
    u3_req_ready   = 1'b0;

    // Everything asserted while in reset: outputs must stay quiet.
    host_req_valid    = 4'b1111;
    udev_req_ready    = 1'b1;
    udev_resp_valid   = 1'b1;
    udev_resp_cmd     = '0;
    udev_resp_srcaddr = '0;
    udev_resp_data    = '0;
    udev_resp_dstaddr = 64'(1) << IDLSB;
    host_resp_ready   = 4'b1111;
    h3_resp_ready     = 3'b111;
    #12;
    chk("rst_req_side", {udev_req_valid, host_req_ready, grant_locked}, 6'b0);
    chk("rst_resp_side", {host_resp_valid, udev_resp_ready}, 5'b0);
    chk("rst_n3", {h3_req_ready, u3_req_valid, u3_grant_locked, h3_resp_valid, u3_resp_ready}, 9'b0);

    host_req_valid  = '0;
    udev_req_ready  = 1'b0;
    udev_resp_valid = 1'b0;
    host_resp_ready = '0;
    h3_resp_ready   = '0;
    #10;
    nreset = 1'b1;

    for (int k = 0; k < 16; k++) apply_row(tbl[k], k);

    chk("n3_req_idle", {u3_req_valid, h3_req_ready, u3_grant_locked, u3_req_cmd,
                        u3_req_dstaddr, u3_req_srcaddr, u3_req_data}, '0);

    // Async reset in the middle of a locked stall.
    apply_row('{4'b0100, 1'b0, 1'b1, 4'b0000, 2, 1'b0}, 20);
    apply_row('{4'b0100, 1'b0, 1'b1, 4'b0000, 2, 1'b1}, 21);
    #1;
    nreset = 1'b0;
    #1;
    chk("arst_immediate", {udev_req_valid, host_req_ready, grant_locked}, 6'b0);
    host_req_valid = 4'b1111;
    udev_req_ready = 1'b1;
    @(negedge clk);
    chk("arst_held", {udev_req_valid, host_req_ready, grant_locked}, 6'b0);
    host_req_valid = '0;
    udev_req_ready = 1'b0;
    #1;
    nreset = 1'b1;
    apply_row('{4'b1111, 1'b1, 1'b1, 4'b0001, 0, 1'b0}, 22);
    apply_row('{4'b1111, 1'b1, 1'b1, 4'b0010, 1, 1'b0}, 23);
    apply_row('{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0}, 24);

    for (int k = 0; k < 9; k++) apply_resp(rtbl[k], k);

    chk("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
